input_stimulus_gen: RTL

Synthesizable, parametrised pseudo-random generator for player directional inputs (up/down/left/right and wider button sets). It drives the game core's button inputs during on-chip soak tests and simulation, replacing behavioural random stimulus. Compared with a fixed 4-input random source, it adds N channels, a reloadable LFSR seed, a configurable hold interval and exclusivity modes that rule out illegal combinations.

---
 rtl/input_stimulus_gen_pkg.sv | 36 +++
 rtl/input_stimulus_gen_lfsr.sv | 28 ++
 rtl/input_stimulus_gen.sv | 127 ++++++++++++
 3 files changed

// File: rtl/input_stimulus_gen_pkg.sv
// Shared constants, types and helpers for the input stimulus generator.
package stim_pkg;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

    localparam int MODE_INDEP  = 0;
    localparam int MODE_ONEHOT = 1;
    localparam int MODE_PAIR   = 2;

    typedef enum logic {
        IDLE,
        RUN
    } stim_state_t;

    // Bits needed to express 0..num_ch, so "no button" gets its own code.
    function automatic int idx_width(input int num_ch);
        return $clog2(num_ch + 1);
    endfunction

    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'(TAPS_8);
            16:      return 32'(TAPS_16);
            32:      return TAPS_32;
            default: return 32'h0;
        endcase
    endfunction

    // One right-shifting Galois step; narrower LFSRs are zero-extended.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] taps);
        return (s >> 1) ^ (s[0] ? taps : 32'h0);
    endfunction

endpackage

// File: rtl/input_stimulus_gen_lfsr.sv
// Right-shifting Galois LFSR with a synchronous seed load that never lets the
// register lock up at zero.
module lfsr_galois
    import stim_pkg::*;
#(
    parameter int          W    = 16,
    parameter logic [W-1:0] TAPS = W'(16'hB400),
    parameter logic [W-1:0] INIT = W'(1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         advance,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
        end else if (load) begin
            state <= (load_val == '0) ? W'(1) : load_val;
        end else if (advance) begin
            state <= W'(lfsr_step(32'(state), 32'(TAPS)));
        end
    end

endmodule

// File: rtl/input_stimulus_gen.sv
// Pseudo-random button stimulus with hold interval and exclusivity modes.
// Build option STIM_HOLD_RAND_EN randomises each run hold by up to 15 extra clocks.
module input_stimulus_gen
    import stim_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] SEED        = LFSR_W'(16'h0001),
    parameter int                HOLD_CYCLES = 2,
    parameter int                MODE        = MODE_INDEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [NUM_CH-1:0] btn,
    output logic              update,
    output logic [15:0]       update_count
);

    localparam int                IDX_W       = idx_width(NUM_CH);
    localparam int                CNT_W       = $clog2(HOLD_CYCLES + 16);
    localparam logic [LFSR_W-1:0] TAPS        = LFSR_W'(lfsr_taps(LFSR_W));
    localparam logic [LFSR_W-1:0] SEED_NZ     = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam logic [CNT_W-1:0]  HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    genvar gi;

    stim_state_t       state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next, run_reload;
    logic [NUM_CH-1:0] btn_reg, btn_next, btn_mapped;
    logic              update_reg, fire;
    logic [15:0]       count_reg;
    logic [LFSR_W-1:0] lfsr_state, lfsr_next;
    logic              lfsr_next_unused;

    lfsr_galois #(
        .W    (LFSR_W),
        .TAPS (TAPS),
        .INIT (SEED_NZ)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (seed_load),
        .advance  (fire),
        .load_val (seed_in),
        .state    (lfsr_state)
    );

    // Value the LFSR takes on an update edge; the new pattern is drawn from it.
    assign lfsr_next        = LFSR_W'(lfsr_step(32'(lfsr_state), 32'(TAPS)));
    assign lfsr_next_unused = ^lfsr_next;

    generate
        if (MODE == MODE_ONEHOT) begin : g_onehot
            logic [IDX_W-1:0] idx;
            assign idx = lfsr_next[LFSR_W-1 -: IDX_W];
            for (gi = 0; gi < NUM_CH; gi++) begin : g_bit
                assign btn_mapped[gi] = (idx == IDX_W'(gi));
            end
        end else if (MODE == MODE_PAIR) begin : g_pair
            logic [NUM_CH-1:0] raw;
            assign raw = lfsr_next[LFSR_W-1 -: NUM_CH];
            // Opposing directions pressed together are dropped as a pair.
            for (gi = 0; gi < NUM_CH / 2; gi++) begin : g_axis
                assign btn_mapped[2*gi]   = raw[2*gi]   & ~raw[2*gi+1];
                assign btn_mapped[2*gi+1] = raw[2*gi+1] & ~raw[2*gi];
            end
        end else begin : g_indep
            assign btn_mapped = lfsr_next[LFSR_W-1 -: NUM_CH];
        end
    endgenerate

`ifdef STIM_HOLD_RAND_EN
    assign run_reload = HOLD_RELOAD + CNT_W'(lfsr_next[3:0]);
`else
    assign run_reload = HOLD_RELOAD;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else if (!seed_load) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = en ? RUN : IDLE;
    end

    always_comb begin
        fire     = 1'b0;
        cnt_next = cnt_reg;
        btn_next = btn_reg;
        if (seed_load || state_reg == IDLE || !en) begin
            cnt_next = HOLD_RELOAD;
            btn_next = '0;
        end else if (cnt_reg == '0) begin
            fire     = 1'b1;
            cnt_next = run_reload;
            btn_next = btn_mapped;
        end else begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg    <= HOLD_RELOAD;
            btn_reg    <= '0;
            update_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            cnt_reg    <= cnt_next;
            btn_reg    <= btn_next;
            update_reg <= fire;
            count_reg  <= count_reg + 16'(fire);
        end
    end

    assign btn          = btn_reg;
    assign update       = update_reg;
    assign update_count = count_reg;

endmodule
